// File: rtl/dpram_pkg.sv
// Shared types and defaults for the dual-port RAM port-A initiator.
// The read tag pairs a valid flag with the address of the word in flight.
package dpram_pkg;

  localparam int DPRAM_ADDR_WIDTH = 5;
  localparam int DPRAM_DATA_WIDTH = 8;
  localparam int DPRAM_LEN_WIDTH  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic                        valid;
    logic [DPRAM_ADDR_WIDTH-1:0] addr;
  } rd_tag_t;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Fixed-depth delay line for read tags; a synchronous reset flushes
// every stage so no response can emerge for beats issued before it.
module dpram_rd_pipe #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;

  tag_t stage_r [DEPTH];

  // Shift tags one stage per clock, flushing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0].valid <= in_valid;
      stage_r[0].addr  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out_valid = stage_r[DEPTH-1].valid;
  assign out_addr  = stage_r[DEPTH-1].addr;

endmodule

// File: rtl/dpram_port_master.sv
// Port-A initiator: turns a valid/ready request stream into registered RAM
// pin activity (single writes, incrementing read bursts) and tagged read responses.
module dpram_port_master
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = DPRAM_LEN_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_A,
  input  logic                  rst_A,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] datain_A,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic                  wr_enA,
  output logic                  enA,
  input  logic [DATA_WIDTH-1:0] dataout_A,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  state_e                state_r;
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  wr_en_r;
  logic                  en_n_r;
  logic                  rsp_valid_r;
  logic [ADDR_WIDTH-1:0] rsp_addr_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  rd_beat_s;
  logic                  tag_valid_s;
  logic [ADDR_WIDTH-1:0] tag_addr_s;

  // Ready when idle or on the last beat of a command, never while in reset.
  always_comb begin
    ready_s = 1'b0;
    if (rst_A) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  ready_s = 1'b1;
        ST_ISSUE: ready_s = (cnt_r == {LEN_WIDTH{1'b0}});
        default:  ready_s = 1'b0;
      endcase
    end
  end

  assign req_ready = ready_s;
  assign accept_s  = req_valid & ready_s;

  // Command sequencer: load on accept, step through burst beats, else fall idle.
  always_ff @(posedge clk_A) begin
    if (rst_A) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LEN_WIDTH{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      wr_en_r <= 1'b0;
      en_n_r  <= 1'b1;
    end else if (accept_s) begin
      state_r <= ST_ISSUE;
      cnt_r   <= req_write ? {LEN_WIDTH{1'b0}} : req_len;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wr_en_r <= req_write;
      en_n_r  <= 1'b0;
    end else if ((state_r == ST_ISSUE) && (cnt_r != {LEN_WIDTH{1'b0}})) begin
      // Address wraps naturally at the top of the address space.
      state_r <= ST_ISSUE;
      cnt_r   <= cnt_r - LEN_WIDTH'(1);
      addr_r  <= addr_r + ADDR_WIDTH'(1);
      en_n_r  <= 1'b0;
    end else begin
      state_r <= ST_IDLE;
      wr_en_r <= 1'b0;
      en_n_r  <= 1'b1;
    end
  end

  assign enA      = en_n_r;
  assign wr_enA   = wr_en_r;
  assign addr_A   = addr_r;
  assign datain_A = wdata_r;

  // A read beat is on the pins this cycle; its tag meets the data RD_LATENCY
  // cycles later and the response register below adds the final stage.
  assign rd_beat_s = (state_r == ST_ISSUE) & ~wr_en_r;

  dpram_rd_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk_A),
    .rst       (rst_A),
    .in_valid  (rd_beat_s),
    .in_addr   (addr_r),
    .out_valid (tag_valid_s),
    .out_addr  (tag_addr_s)
  );

  // Response stage: capture RAM data alongside its emerging tag.
  always_ff @(posedge clk_A) begin
    if (rst_A) begin
      rsp_valid_r <= 1'b0;
      rsp_addr_r  <= {ADDR_WIDTH{1'b0}};
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
    end else if (tag_valid_s) begin
      rsp_valid_r <= 1'b1;
      rsp_addr_r  <= tag_addr_s;
      rsp_data_r  <= dataout_A;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_addr  = rsp_addr_r;
  assign rsp_data  = rsp_data_r;

endmodule
